// File: rtl/dcp_tx_printer.sv
// dcp_tx_printer
// ----------------------------------------------------------------------------
// Shared output formatter for the debug command modules (P, D, I, T, B, G, R).
// A command module hands over either one raw character or a 32-bit word to be
// printed as hex digits, optionally followed by a suffix character. This block
// turns that request into a byte stream on the UART TX valid/ready interface,
// so no command module ever has to build ASCII itself. Downstream sits the DCP
// TX switch, which feeds uart_tx.
//
// Parameters:
//   NIBBLES   : hex digits printed in word mode, taken from the low end of din
//               (legal range 1..8)
//   HEX_UPPER : 1 prints digits 10..15 as 'A'-'F', 0 prints them as 'a'-'f'
//
// Ports:
//   clk      in   1  system clock
//   rst      in   1  synchronous, active-high reset
//   req      in   1  print request, only looked at while idle
//   req_type in   1  0 = raw character din[7:0], 1 = hex word
//   din      in  32  data to print, captured when the request is accepted
//   suffix   in   8  character appended after the payload, 8'h00 = none
//   busy     out  1  high from the cycle after acceptance through the done cycle
//   done     out  1  one-cycle pulse after the final byte handshake
//   rdy_tx   in   1  UART TX ready
//   vld_tx   out  1  byte valid toward UART TX
//   d_tx     out  8  byte toward UART TX
// ----------------------------------------------------------------------------
module dcp_tx_printer #(
  parameter int unsigned NIBBLES   = 8,
  parameter bit          HEX_UPPER = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        req_type,
  input  logic [31:0] din,
  input  logic [7:0]  suffix,
  output logic        busy,
  output logic        done,
  input  logic        rdy_tx,
  output logic        vld_tx,
  output logic [7:0]  d_tx
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of payload bytes in word mode; at most 8, so 4 bits suffice
  // together with the optional suffix (maximum total of 9).
  localparam logic [3:0] WORD_LEN = 4'(NIBBLES);

  state_t      state_q;
  state_t      state_d;

  logic [31:0] data_q;
  logic        type_q;
  logic [7:0]  suffix_q;
  logic [3:0]  count_q;
  logic [3:0]  idx_q;
  logic [7:0]  d_q;

  logic        last_byte;
  logic        xfer;

  // Map one nibble to its ASCII hex digit.
  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    logic [7:0] c;
    if (nib < 4'd10) begin
      c = 8'h30 + {4'h0, nib};
    end else if (HEX_UPPER) begin
      c = 8'h41 + {4'h0, nib - 4'd10};
    end else begin
      c = 8'h61 + {4'h0, nib - 4'd10};
    end
    return c;
  endfunction

  // Byte at position idx of the output stream for a given request. Any
  // position past the payload can only be the suffix, which is why it is the
  // default; the byte count guarantees we never ask for it when it is zero.
  function automatic logic [7:0] byte_at(
    input logic [31:0] data,
    input logic        is_word,
    input logic [7:0]  sfx,
    input logic [3:0]  idx
  );
    logic [7:0] b;
    logic [3:0] nib_pos;
    logic [3:0] nib;
    b = sfx;
    if (is_word) begin
      if (idx < WORD_LEN) begin
        // Digits go out most significant first, so position 0 is the top
        // nibble of the printed field.
        nib_pos = WORD_LEN - 4'd1 - idx;
        nib     = 4'(data >> {nib_pos, 2'b00});
        b       = hex_char(nib);
      end
    end else if (idx == 4'd0) begin
      b = data[7:0];
    end
    return b;
  endfunction

  // Total bytes in a print: the payload plus one more for a non-zero suffix.
  function automatic logic [3:0] byte_count(
    input logic       is_word,
    input logic [7:0] sfx
  );
    logic [3:0] n;
    n = is_word ? WORD_LEN : 4'd1;
    if (sfx != 8'h00) begin
      n = n + 4'd1;
    end
    return n;
  endfunction

  assign last_byte = (idx_q == (count_q - 4'd1));
  assign xfer      = vld_tx && rdy_tx;
  assign d_tx      = d_q;

  // State register. Reset is synchronous, so a print in flight is simply
  // abandoned at the next edge without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and output decode. vld_tx, busy and done are pure decodes of
  // the registered state, so they change only on clock edges.
  always_comb begin
    state_d = state_q;
    vld_tx  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = SEND;
        end
      end
      SEND: begin
        vld_tx = 1'b1;
        busy   = 1'b1;
        if (rdy_tx && last_byte) begin
          state_d = DONE;
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request latches, byte index and the registered output byte. The first
  // byte is computed from the live inputs at acceptance so it is already on
  // d_tx in the first SEND cycle; every later byte is computed from the
  // latched copy, which makes the print immune to input changes mid-stream.
  // The index advances only on a real handshake, so ready toggling can never
  // skip or repeat a byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q   <= 32'h0;
      type_q   <= 1'b0;
      suffix_q <= 8'h00;
      count_q  <= 4'd0;
      idx_q    <= 4'd0;
      d_q      <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            data_q   <= din;
            type_q   <= req_type;
            suffix_q <= suffix;
            count_q  <= byte_count(req_type, suffix);
            idx_q    <= 4'd0;
            d_q      <= byte_at(din, req_type, suffix, 4'd0);
          end
        end
        SEND: begin
          if (xfer) begin
            if (last_byte) begin
              idx_q <= 4'd0;
              d_q   <= 8'h00;
            end else begin
              idx_q <= idx_q + 4'd1;
              d_q   <= byte_at(data_q, type_q, suffix_q, idx_q + 4'd1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcp_tx_printer.sv
// tb_dcp_tx_printer
// ----------------------------------------------------------------------------
// Self-checking bench for dcp_tx_printer. Two instances are exercised: the
// default configuration (8 upper-case digits) and a narrow lower-case one
// (2 digits). A table of hand-derived prints covers the named scenarios, a
// few hand-written sequences cover reset mid-print and back-to-back requests,
// and a randomized phase compares against a reference model that builds the
// expected byte string directly from the formatting rules.
// ----------------------------------------------------------------------------
module tb_dcp_tx_printer;

  localparam int CYCLE_BUDGET = 300;

  logic        clk;
  logic        rst;
  logic        req8;
  logic        req2;
  logic        req_type;
  logic [31:0] din;
  logic [7:0]  suffix;
  logic        rdy_tx;

  logic        busy8;
  logic        done8;
  logic        vld8;
  logic [7:0]  d8;
  logic        busy2;
  logic        done2;
  logic        vld2;
  logic [7:0]  d2;

  // Selected-instance view used by all per-cycle checks.
  logic        sel2;
  logic        s_busy;
  logic        s_done;
  logic        s_vld;
  logic [7:0]  s_d;

  int          n_checks;
  int          n_fail;

  logic [7:0]  cap[$];
  logic [7:0]  exp_q[$];
  int          done_cnt;
  logic        pv;
  logic        pr;
  logic [7:0]  pd;

  typedef struct {
    bit          use2;
    logic        typ;
    logic [31:0] din;
    logic [7:0]  sfx;
    int          mode;
    bit          req_in_send;
    int          len;
    logic [71:0] exp;
  } vec_t;

  vec_t vecs[9];

  dcp_tx_printer dut8 (
    .clk      (clk),
    .rst      (rst),
    .req      (req8),
    .req_type (req_type),
    .din      (din),
    .suffix   (suffix),
    .busy     (busy8),
    .done     (done8),
    .rdy_tx   (rdy_tx),
    .vld_tx   (vld8),
    .d_tx     (d8)
  );

  dcp_tx_printer #(.NIBBLES(2), .HEX_UPPER(1'b0)) dut2 (
    .clk      (clk),
    .rst      (rst),
    .req      (req2),
    .req_type (req_type),
    .din      (din),
    .suffix   (suffix),
    .busy     (busy2),
    .done     (done2),
    .rdy_tx   (rdy_tx),
    .vld_tx   (vld2),
    .d_tx     (d2)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign s_busy = sel2 ? busy2 : busy8;
  assign s_done = sel2 ? done2 : done8;
  assign s_vld  = sel2 ? vld2  : vld8;
  assign s_d    = sel2 ? d2    : d8;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the byte string a print should produce, derived from
  // the formatting rules with plain arithmetic.
  task automatic buildExpected(input bit use2, input logic typ, input logic [31:0] d,
                               input logic [7:0] sfx);
    int nib;
    bit upper;
    int v;
    nib   = use2 ? 2 : 8;
    upper = use2 ? 1'b0 : 1'b1;
    exp_q.delete();
    if (typ) begin
      for (int i = nib - 1; i >= 0; i--) begin
        v = int'((d >> (4 * i)) & 32'hF);
        if (v < 10) exp_q.push_back(8'(48 + v));
        else        exp_q.push_back(8'((upper ? 65 : 97) + v - 10));
      end
    end else begin
      exp_q.push_back(d[7:0]);
    end
    if (sfx != 8'h00) exp_q.push_back(sfx);
  endtask

  // One negedge sample of the selected instance: stability under stall,
  // capture of handshaken bytes, done counting and busy coverage.
  task automatic sampleCycle();
    if (pv && !pr) begin
      check("hold_vld", s_vld, 1);
      check("hold_byte", s_d, pd);
    end
    if (s_vld && rdy_tx) cap.push_back(s_d);
    if (s_done) begin
      done_cnt++;
      check("vld_in_done", s_vld, 0);
    end
    if (s_vld || s_done) check("busy_active", s_busy, 1);
    pv = s_vld;
    pr = rdy_tx;
    pd = s_d;
  endtask

  // Drive ready per mode (0 always, 1 three low cycles before each high,
  // 2 random) until done is seen or the cycle budget runs out.
  task automatic waitDone(input int mode, input bit req_in_send, output bit seen,
                          output int done_cyc);
    int cyc;
    int phase;
    seen     = 1'b0;
    done_cyc = 0;
    cyc      = 1;
    phase    = 0;
    while (cyc <= CYCLE_BUDGET && !seen) begin
      case (mode)
        0:       rdy_tx = 1'b1;
        1:       rdy_tx = (phase == 3);
        default: rdy_tx = 1'($urandom_range(0, 1));
      endcase
      phase = (phase + 1) % 4;
      if (req_in_send && cyc == 1) begin
        if (sel2) req2 = 1'b1;
        else      req8 = 1'b1;
      end
      @(negedge clk);
      sampleCycle();
      if (s_done) begin
        seen     = 1'b1;
        done_cyc = cyc;
      end
      @(posedge clk);
      #1;
      req8 = 1'b0;
      req2 = 1'b0;
      cyc++;
    end
    check("done_seen", 32'(seen), 1);
  endtask

  task automatic checkOutput(input int mode, input bit seen, input int done_cyc);
    check("byte_count", cap.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < cap.size()) check($sformatf("byte%0d", i), 32'(cap[i]), 32'(exp_q[i]));
    end
    check("done_pulses", done_cnt, 1);
    if (mode == 0 && seen) check("done_latency", done_cyc, exp_q.size() + 1);
  endtask

  // Full print: request, scramble inputs after acceptance, run to done,
  // watch two idle cycles for stray output, then compare against exp_q.
  task automatic applyStimulus(input bit use2, input logic typ, input logic [31:0] d,
                               input logic [7:0] sfx, input int mode, input bit req_in_send);
    bit seen;
    int done_cyc;
    sel2     = use2;
    cap.delete();
    done_cnt = 0;
    pv       = 1'b0;
    @(posedge clk);
    #1;
    req_type = typ;
    din      = d;
    suffix   = sfx;
    if (use2) req2 = 1'b1;
    else      req8 = 1'b1;
    @(posedge clk);
    #1;
    req8     = 1'b0;
    req2     = 1'b0;
    req_type = ~typ;
    din      = $urandom;
    suffix   = 8'($urandom);
    check("first_vld", s_vld, 1);
    check("first_byte", s_d, exp_q[0]);
    check("busy_start", s_busy, 1);
    waitDone(mode, req_in_send, seen, done_cyc);
    check("done_low_after", s_done, 0);
    check("busy_low_after", s_busy, 0);
    check("vld_low_after", s_vld, 0);
    repeat (2) begin
      @(negedge clk);
      sampleCycle();
      @(posedge clk);
      #1;
    end
    checkOutput(mode, seen, done_cyc);
  endtask

  initial begin
    bit seen;
    int done_cyc;

    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    req8     = 1'b0;
    req2     = 1'b0;
    req_type = 1'b0;
    din      = 32'h0;
    suffix   = 8'h00;
    rdy_tx   = 1'b0;
    sel2     = 1'b0;
    done_cnt = 0;
    pv       = 1'b0;
    pr       = 1'b0;
    pd       = 8'h00;

    vecs[0] = '{1'b0, 1'b1, 32'h1234ABCD, 8'h20, 0, 1'b0, 9,
                {8'h31, 8'h32, 8'h33, 8'h34, 8'h41, 8'h42, 8'h43, 8'h44, 8'h20}};
    vecs[1] = '{1'b0, 1'b1, 32'h1234ABCD, 8'h20, 1, 1'b0, 9,
                {8'h31, 8'h32, 8'h33, 8'h34, 8'h41, 8'h42, 8'h43, 8'h44, 8'h20}};
    vecs[2] = '{1'b0, 1'b0, 32'h0000000A, 8'h00, 0, 1'b1, 1, {8'h0A, 64'h0}};
    vecs[3] = '{1'b1, 1'b1, 32'hFFFFFF9E, 8'h0D, 0, 1'b0, 3, {8'h39, 8'h65, 8'h0D, 48'h0}};
    vecs[4] = '{1'b0, 1'b0, 32'hABCDEF00, 8'h00, 0, 1'b0, 1, {8'h00, 64'h0}};
    vecs[5] = '{1'b0, 1'b1, 32'h00000000, 8'h00, 2, 1'b0, 8, {64'h3030303030303030, 8'h00}};
    vecs[6] = '{1'b1, 1'b1, 32'h000000AB, 8'h00, 2, 1'b0, 2, {8'h61, 8'h62, 56'h0}};
    vecs[7] = '{1'b0, 1'b0, 32'h123456FF, 8'h0D, 1, 1'b0, 2, {8'hFF, 8'h0D, 56'h0}};
    vecs[8] = '{1'b0, 1'b1, 32'hFEDCBA98, 8'h3A, 2, 1'b0, 9,
                {8'h46, 8'h45, 8'h44, 8'h43, 8'h42, 8'h41, 8'h39, 8'h38, 8'h3A}};

    // Reset state of both instances.
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy8", busy8, 0);
    check("rst_done8", done8, 0);
    check("rst_vld8", vld8, 0);
    check("rst_d8", d8, 0);
    check("rst_busy2", busy2, 0);
    check("rst_vld2", vld2, 0);
    check("rst_d2", d2, 0);
    rst = 1'b0;

    $display("[TB] table-driven prints");
    for (int i = 0; i < 9; i++) begin
      exp_q.delete();
      for (int b = 0; b < vecs[i].len; b++) exp_q.push_back(vecs[i].exp[71 - 8 * b -: 8]);
      applyStimulus(vecs[i].use2, vecs[i].typ, vecs[i].din, vecs[i].sfx,
                    vecs[i].mode, vecs[i].req_in_send);
    end

    $display("[TB] reset mid-print");
    sel2     = 1'b0;
    cap.delete();
    done_cnt = 0;
    pv       = 1'b0;
    @(posedge clk);
    #1;
    req_type = 1'b1;
    din      = 32'h1234ABCD;
    suffix   = 8'h20;
    rdy_tx   = 1'b1;
    req8     = 1'b1;
    @(posedge clk);
    #1;
    req8 = 1'b0;
    repeat (3) begin
      @(negedge clk);
      sampleCycle();
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_vld", vld8, 0);
    check("rst_mid_d", d8, 0);
    check("rst_mid_busy", busy8, 0);
    check("rst_mid_done", done8, 0);
    rst = 1'b0;
    check("rst_mid_bytes", cap.size(), 3);
    check("rst_mid_no_done", done_cnt, 0);
    buildExpected(1'b0, 1'b1, 32'h1234ABCD, 8'h20);
    applyStimulus(1'b0, 1'b1, 32'h1234ABCD, 8'h20, 0, 1'b0);

    $display("[TB] back-to-back requests");
    sel2     = 1'b0;
    cap.delete();
    done_cnt = 0;
    pv       = 1'b0;
    @(posedge clk);
    #1;
    req_type = 1'b0;
    din      = 32'h00000058;
    suffix   = 8'h00;
    rdy_tx   = 1'b1;
    req8     = 1'b1;
    @(posedge clk);
    #1;
    req8 = 1'b0;
    @(posedge clk);
    #1;
    check("b2b_in_done", done8, 1);
    req8 = 1'b1;
    din  = 32'h00000041;
    @(posedge clk);
    #1;
    check("b2b_first_ignored_vld", vld8, 0);
    check("b2b_first_ignored_busy", busy8, 0);
    din = 32'h00000042;
    @(posedge clk);
    #1;
    req8 = 1'b0;
    check("b2b_second_vld", vld8, 1);
    check("b2b_second_byte", d8, 8'h42);
    cap.delete();
    done_cnt = 0;
    pv       = 1'b0;
    exp_q.delete();
    exp_q.push_back(8'h42);
    waitDone(0, 1'b0, seen, done_cyc);
    repeat (2) begin
      @(negedge clk);
      sampleCycle();
      @(posedge clk);
      #1;
    end
    checkOutput(0, seen, done_cyc);

    $display("[TB] randomized prints against reference model");
    for (int i = 0; i < 30; i++) begin
      bit          use2;
      logic        typ;
      logic [31:0] d;
      logic [7:0]  sfx;
      use2 = 1'($urandom_range(0, 1));
      typ  = 1'($urandom_range(0, 1));
      d    = $urandom;
      sfx  = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
      buildExpected(use2, typ, d, sfx);
      applyStimulus(use2, typ, d, sfx, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dcp_tx_printer.md
Name: dcp_tx_printer

Overview:
- Shared output formatter for the debug command modules (P, D, I, T, B, G, R).
- Takes a request to print one raw character or a hex-formatted word with an optional suffix character.
- Serialises the request byte-by-byte onto the UART TX valid/ready interface.
- Sits directly downstream of each command module and directly upstream of the DCP TX switch, which feeds uart_tx. Command modules therefore never build ASCII themselves.

Parameters:
- NIBBLES, 8: number of hex digits printed in word mode, taken from the low end of din. Legal range 1..8.
- HEX_UPPER, 1: 1 selects 'A'-'F' (0x41-0x46) for digits 10..15; 0 selects 'a'-'f' (0x61-0x66).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- req  input  1  print request; sampled only in IDLE
- type  input  1  0 = single raw character din[7:0]; 1 = hex word
- din  input  32  data to print; latched on request acceptance
- suffix  input  8  character appended after the payload; 0x00 = no suffix
- busy  output  1  high from the cycle after acceptance until the DONE cycle, inclusive
- done  output  1  one-cycle pulse after the final byte handshake
- rdy_tx  input  1  UART TX ready
- vld_tx  output  1  byte valid toward UART TX
- d_tx  output  8  byte toward UART TX

Behaviour:
- Reset values: busy=0, done=0, vld_tx=0, d_tx=8'h00. State is IDLE and all latches are cleared.
- States: IDLE, SEND, DONE.
- IDLE:
  - On req=1, latch din, type and suffix. Compute byte count: type 0 gives 1, type 1 gives NIBBLES; add 1 if suffix != 0. Clear index; go to SEND.
  - req=0: stay in IDLE.
- SEND:
  - vld_tx=1. d_tx = byte[index], registered so it is stable throughout.
  - A byte transfers on any cycle with vld_tx && rdy_tx; index then increments and d_tx updates on the next edge.
  - vld_tx stays high and d_tx stays unchanged while rdy_tx=0.
  - The transfer of the last byte moves to DONE, with vld_tx=0 from the next cycle.
- DONE: done=1 and busy=1 for exactly one cycle, then go to IDLE.
- Byte sequence, type 1:
  - Bytes are digits from nibble NIBBLES-1 down to nibble 0, most significant first, then the suffix if non-zero.
  - Nibble values 0-9 map to 0x30-0x39; 10-15 map to letters according to HEX_UPPER.
- Byte sequence, type 0: din[7:0] sent verbatim (no translation, 0x00 allowed), then the suffix if non-zero.
- Latency:
  - req accepted at edge N gives vld_tx=1 with the first byte at cycle N+1.
  - With rdy_tx held high, one byte transfers per cycle.
  - done follows the cycle after the last transfer.
- Rule: req in SEND or DONE is ignored, not queued. A new request is accepted in IDLE only, i.e. from the cycle after done at the earliest.
- Rule: din, type and suffix changes after acceptance have no effect on the print in progress.
- Rule: rst asserted mid-print returns to IDLE at the next edge with vld_tx=0 and d_tx=0. No done pulse is produced and the partial output is abandoned.
- Rule: rdy_tx toggling between cycles must never cause a skipped or duplicated byte. Exactly one increment occurs per vld_tx&&rdy_tx cycle.
- Rule: the index counter is 4 bits. The maximum count is 9, so no wrap occurs.

Test Plan:
1. Word print, continuous ready: type=1, din=32'h1234ABCD, suffix=0x20, rdy_tx=1.
   - Required: bytes 31 32 33 34 41 42 43 44 20 on 9 consecutive cycles, starting the cycle after req.
   - Required: done pulses once on the following cycle; busy falls after done.
2. Back-pressure: same request with rdy_tx low for 3 cycles before each transfer.
   - Required: d_tx held stable while vld_tx=1.
   - Required: exact byte sequence as in scenario 1; 9 transfers total; single done pulse.
3. Char print, no suffix: type=0, din[7:0]=0x0A, suffix=0.
   - Required: exactly one byte 0x0A, then done.
   - Required: a req asserted during SEND produces no extra output.
4. Parameter variants: NIBBLES=2, HEX_UPPER=0, type=1, din=32'hFFFFFF9e, suffix=0x0D.
   - Required: bytes 39 65 0D, then done.
5. Reset mid-print: assert rst after the 3rd byte transfer of scenario 1.
   - Required: vld_tx=0 and d_tx=0 next cycle; no done pulse.
   - Required: a fresh request then prints its full sequence from the first byte.
6. Back-to-back: assert req in the DONE cycle, then again in the following IDLE cycle.
   - Required: the first req is ignored.
   - Required: the second starts a new print whose first byte is valid one cycle later.
